// File: rtl/pc_gen_pip_pkg.sv
// Shared types and helpers for the fetch-stage PC generator.
package pc_gen_pkg;

  typedef enum logic [2:0] {SRC_SEQ, SRC_HOLD, SRC_RET, SRC_JUMP, SRC_BR} pc_src_t;

  localparam int                    ADDR_MAX_W = 64;
  localparam logic [ADDR_MAX_W-1:0] ALIGN_MASK = ~64'h3;

  // Instruction fetches are word-aligned, so redirect targets drop their low two bits.
  function automatic logic [ADDR_MAX_W-1:0] align(input logic [ADDR_MAX_W-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_gen_pip_if.sv
// Redirect/stall inputs and PC outputs of the fetch-stage PC generator.
interface pc_gen_pip_if #(parameter int WL = 32);
  logic          stall;
  logic          br_taken;
  logic [WL-1:0] br_target;
  logic          jump;
  logic [WL-1:0] jump_target;
  logic          call;
  logic [WL-1:0] link_addr;
  logic          ret;
  logic [WL-1:0] pc_out;
  logic [WL-1:0] pc_next;
  logic          ras_empty;

  modport master (
    output stall, br_taken, br_target, jump, jump_target, call, link_addr, ret,
    input  pc_out, pc_next, ras_empty
  );

  modport slave (
    input  stall, br_taken, br_target, jump, jump_target, call, link_addr, ret,
    output pc_out, pc_next, ras_empty
  );
endinterface

// File: rtl/pc_gen_pip_ras_stack.sv
// Circular return-address stack: overflow overwrites the oldest entry, count saturates.
module ras_stack #(
  parameter int WL        = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  logic [WL-1:0] din,
  output logic [WL-1:0] top,
  output logic          empty
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WL-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;

  // r_ptr is the next write slot; the top sits one below it (wraps with PW bits).
  assign top   = r_mem[r_ptr - PW'(1)];
  assign empty = (r_cnt == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (push) begin
      r_mem[r_ptr] <= din;
      r_ptr        <= r_ptr + PW'(1);
      if (r_cnt != CW'(RAS_DEPTH)) r_cnt <= r_cnt + CW'(1);
    end else if (pop && !empty) begin
      r_ptr <= r_ptr - PW'(1);
      r_cnt <= r_cnt - CW'(1);
    end
  end
endmodule

// File: rtl/pc_gen_pip.sv
// Fetch-stage PC generator: sequential advance, stall hold, EX branch / ID jump redirects.
// Optional JR $ra prediction via a return-address stack when PC_GEN_RAS_EN is defined.
module pc_gen_pip
  import pc_gen_pkg::*;
#(
  parameter int            WL        = 32,
  parameter logic [WL-1:0] RESET_VEC = '0,
  parameter int            INC       = 4,
  parameter int            RAS_DEPTH = 4
) (
  input logic         CLK,
  input logic         RST,
  pc_gen_pip_if.slave bus
);
  logic [WL-1:0] r_pc;
  logic [WL-1:0] w_pc_next;
  logic [WL-1:0] w_ras_top;
  logic          w_ras_empty;
  logic          w_push;
  logic          w_pop;
  pc_src_t       w_src;

  // An EX redirect squashes the ID instruction, so it also blocks stack updates.
  assign w_push = bus.jump & bus.call & ~bus.stall & ~bus.br_taken;
  assign w_pop  = bus.ret & ~bus.call & ~bus.stall & ~bus.br_taken & ~w_ras_empty;

`ifdef PC_GEN_RAS_EN
  ras_stack #(.WL(WL), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .CLK   (CLK),
    .RST   (RST),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.link_addr),
    .top   (w_ras_top),
    .empty (w_ras_empty)
  );
`else
  logic w_unused;
  assign w_ras_top   = '0;
  assign w_ras_empty = 1'b1;
  assign w_unused    = ^{bus.link_addr, w_push, w_pop};
`endif

  always_comb begin
    w_src = SRC_SEQ;
    if (bus.br_taken)                               w_src = SRC_BR;
    else if (bus.stall)                             w_src = SRC_HOLD;
    else if (bus.ret && !bus.call && !w_ras_empty)  w_src = SRC_RET;
    else if (bus.jump)                              w_src = SRC_JUMP;
  end

  always_comb begin
    w_pc_next = r_pc + WL'(INC);
    case (w_src)
      SRC_BR:   w_pc_next = WL'(align(ADDR_MAX_W'(bus.br_target)));
      SRC_HOLD: w_pc_next = r_pc;
      SRC_RET:  w_pc_next = WL'(align(ADDR_MAX_W'(w_ras_top)));
      SRC_JUMP: w_pc_next = WL'(align(ADDR_MAX_W'(bus.jump_target)));
      default:  w_pc_next = r_pc + WL'(INC);
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_pc <= RESET_VEC;
    else     r_pc <= w_pc_next;
  end

  assign bus.pc_out    = r_pc;
  assign bus.pc_next   = w_pc_next;
  assign bus.ras_empty = w_ras_empty;
endmodule

// File: tb/tb_pc_gen_pip.sv
// Self-checking bench for pc_gen_pip; reference model keeps the RAS as a bounded queue.
module tb_pc_gen_pip;
  localparam int          WL    = 32;
  localparam logic [31:0] RVEC  = 32'h100;
  localparam int          DEPTH = 4;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_gen_pip_if #(.WL(WL)) bus ();

  pc_gen_pip #(.WL(WL), .RESET_VEC(RVEC), .INC(4), .RAS_DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  function automatic logic [31:0] al(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] exp_next();
    if (bus.br_taken) return al(bus.br_target);
    if (bus.stall) return m_pc;
    if (RAS_EN && bus.ret && !bus.call && m_ras.size() > 0) return al(m_ras[$]);
    if (bus.jump) return al(bus.jump_target);
    return m_pc + 32'd4;
  endfunction

  function automatic logic exp_empty();
    return RAS_EN ? (m_ras.size() == 0) : 1'b1;
  endfunction

  task automatic idle();
    RST = 0; bus.stall = 0; bus.br_taken = 0; bus.br_target = '0;
    bus.jump = 0; bus.jump_target = '0; bus.call = 0; bus.link_addr = '0; bus.ret = 0;
  endtask

  // Advance model and DUT one clock; leaves time at posedge+1 for sampling.
  task automatic cyc();
    logic [31:0] nxt;
    nxt = exp_next();
    if (RST) begin
      m_pc = RVEC;
      m_ras.delete();
    end else begin
      if (RAS_EN && !bus.stall && !bus.br_taken) begin
        if (bus.jump && bus.call) begin
          m_ras.push_back(bus.link_addr);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (bus.ret && !bus.call && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
      end
      m_pc = nxt;
    end
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic test_reset();
    idle(); RST = 1;
    cyc();
    n_checks++;
    if (bus.pc_out !== 32'h100) begin
      n_fail++; $display("FAIL reset_pc got %h want %h", bus.pc_out, 32'h100);
    end
    n_checks++;
    if (bus.ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_ras_empty got %b want 1", bus.ras_empty);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] want;
    for (int i = 1; i <= 2; i++) begin
      cyc();
      want = 32'h100 + 32'(4 * i);
      n_checks++;
      if (bus.pc_out !== want) begin
        n_fail++; $display("FAIL free_run[%0d] got %h want %h", i, bus.pc_out, want);
      end
    end
  endtask

  task automatic test_stall_branch();
    bus.jump = 1; bus.jump_target = 32'h20;
    cyc();
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1;
      cyc();
      n_checks++;
      if (bus.pc_out !== 32'h20) begin
        n_fail++; $display("FAIL stall_hold[%0d] got %h want %h", i, bus.pc_out, 32'h20);
      end
    end
    bus.stall = 1; bus.br_taken = 1; bus.br_target = 32'h400;
    bus.jump = 1; bus.jump_target = 32'h800;
    #1;
    n_checks++;
    if (bus.pc_next !== 32'h400) begin
      n_fail++; $display("FAIL br_over_stall_next got %h want %h", bus.pc_next, 32'h400);
    end
    cyc();
    n_checks++;
    if (bus.pc_out !== 32'h400) begin
      n_fail++; $display("FAIL br_over_stall got %h want %h", bus.pc_out, 32'h400);
    end
    cyc();
    n_checks++;
    if (bus.pc_out !== 32'h404) begin
      n_fail++; $display("FAIL resume_after_br got %h want %h", bus.pc_out, 32'h404);
    end
  endtask

  task automatic test_misalign_wrap();
    bus.jump = 1; bus.jump_target = 32'h1003;
    cyc();
    n_checks++;
    if (bus.pc_out !== 32'h1000) begin
      n_fail++; $display("FAIL misalign_jump got %h want %h", bus.pc_out, 32'h1000);
    end
    bus.br_taken = 1; bus.br_target = 32'hFFFF_FFFE;
    cyc();
    n_checks++;
    if (bus.pc_out !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL misalign_br got %h want %h", bus.pc_out, 32'hFFFF_FFFC);
    end
    cyc();
    n_checks++;
    if (bus.pc_out !== 32'h0) begin
      n_fail++; $display("FAIL wrap got %h want %h", bus.pc_out, 32'h0);
    end
  endtask

  task automatic test_ras_call_ret();
    logic [31:0] want;
    bus.jump = 1; bus.call = 1; bus.jump_target = 32'h200; bus.link_addr = 32'h48;
    cyc();
    n_checks++;
    if (bus.pc_out !== 32'h200 || bus.ras_empty !== !RAS_EN) begin
      n_fail++; $display("FAIL call got pc %h empty %b want pc %h empty %b",
                         bus.pc_out, bus.ras_empty, 32'h200, !RAS_EN);
    end
    cyc(); cyc();
    bus.ret = 1;
    cyc();
    want = RAS_EN ? 32'h48 : 32'h20C;
    n_checks++;
    if (bus.pc_out !== want || bus.ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL ret got pc %h empty %b want pc %h empty 1",
                         bus.pc_out, bus.ras_empty, want);
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] want;
    logic [31:0] seq;
    for (int i = 1; i <= 5; i++) begin
      bus.jump = 1; bus.call = 1; bus.jump_target = 32'h3000 + 32'(i * 16);
      bus.link_addr = 32'(i * 16);
      cyc();
    end
    seq = m_pc;
    for (int i = 0; i < 5; i++) begin
      bus.ret = 1;
      cyc();
      seq = seq + 32'd4;
      want = (RAS_EN && i < 4) ? 32'(32'h50 - 16 * i) : seq;
      if (RAS_EN && i < 4) seq = want;
      n_checks++;
      if (bus.pc_out !== want || bus.pc_out !== m_pc) begin
        n_fail++; $display("FAIL overflow_ret[%0d] got %h want %h", i, bus.pc_out, want);
      end
      if (i == 2 || i == 3) begin
        n_checks++;
        if (bus.ras_empty !== (i == 3 || !RAS_EN)) begin
          n_fail++; $display("FAIL overflow_empty[%0d] got %b want %b",
                             i, bus.ras_empty, (i == 3 || !RAS_EN));
        end
      end
    end
  endtask

  task automatic test_squash_reset();
    logic [31:0] want;
    bus.jump = 1; bus.call = 1; bus.jump_target = 32'h500; bus.link_addr = 32'h70;
    cyc();
    bus.ret = 1; bus.br_taken = 1; bus.br_target = 32'h600;
    cyc();
    n_checks++;
    if (bus.pc_out !== 32'h600 || bus.ras_empty !== !RAS_EN) begin
      n_fail++; $display("FAIL squash got pc %h empty %b want pc %h empty %b",
                         bus.pc_out, bus.ras_empty, 32'h600, !RAS_EN);
    end
    bus.ret = 1;
    cyc();
    want = RAS_EN ? 32'h70 : 32'h604;
    n_checks++;
    if (bus.pc_out !== want) begin
      n_fail++; $display("FAIL post_squash_ret got %h want %h", bus.pc_out, want);
    end
    bus.jump = 1; bus.call = 1; bus.jump_target = 32'h900; bus.link_addr = 32'h88;
    cyc();
    RST = 1; bus.br_taken = 1; bus.br_target = 32'h700; bus.stall = 1;
    bus.jump = 1; bus.call = 1; bus.jump_target = 32'hA00;
    cyc();
    n_checks++;
    if (bus.pc_out !== RVEC || bus.ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_over_br got pc %h empty %b want pc %h empty 1",
                         bus.pc_out, bus.ras_empty, RVEC);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RST           = ($urandom_range(59) == 0);
      bus.stall     = ($urandom_range(4) == 0);
      bus.br_taken  = ($urandom_range(7) == 0);
      bus.br_target = $urandom;
      bus.jump      = ($urandom_range(3) == 0);
      bus.jump_target = $urandom;
      bus.call      = bus.jump ? ($urandom_range(1) == 0) : ($urandom_range(9) == 0);
      bus.link_addr = $urandom;
      bus.ret       = ($urandom_range(2) == 0);
      #1;
      n_checks++;
      if (bus.pc_next !== exp_next()) begin
        n_fail++; $display("FAIL rand_pc_next[%0d] got %h want %h", i, bus.pc_next, exp_next());
      end
      cyc();
      n_checks++;
      if (bus.pc_out !== m_pc || bus.ras_empty !== exp_empty()) begin
        n_fail++; $display("FAIL rand_state[%0d] got pc %h empty %b want pc %h empty %b",
                           i, bus.pc_out, bus.ras_empty, m_pc, exp_empty());
      end
    end
  endtask

  initial begin
    idle();
    RST  = 1;
    m_pc = RVEC;
    @(negedge CLK);
    test_reset();
    test_free_run();
    test_stall_branch();
    test_misalign_wrap();
    test_ras_call_ret();
    test_ras_overflow();
    test_squash_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_gen_pip.md
# pc_gen_pip

Program-counter generator for the pipelined MIPS fetch stage. Holds the fetch address, advances it sequentially, and applies stall holds and redirects: branches resolved in EX, and jumps decoded in ID. An optional return-address stack (RAS) predicts `JR $ra` targets in ID. It replaces the fixed-table PC stage and drives the instruction-memory address and the IF/ID PC latch.

## Interface
- `WL`, 32: address width.
- `RESET_VEC`, 0: value loaded into `pc_out` on reset.
- `INC`, 4: sequential increment.
- `RAS_DEPTH`, 4: RAS entries; power of two, ≥2.

Ports:
- `CLK`  in  1  clock; all state updates on posedge.
- `RST`  in  1  reset; synchronous, active-high.
- `stall`  in  1  hold request from hazard unit.
- `br_taken`  in  1  EX-resolved redirect: taken branch, or RAS mispredict correction.
- `br_target`  in  WL  target for `br_taken`.
- `jump`  in  1  J/JAL/JR decoded in ID.
- `jump_target`  in  WL  target for `jump`.
- `call`  in  1  qualifies `jump` as JAL: push `link_addr`.
- `link_addr`  in  WL  return address to push.
- `ret`  in  1  JR $ra decoded in ID: pop and predict.
- `pc_out`  out  WL  registered fetch address.
- `pc_next`  out  WL  combinational next PC.
- `ras_empty`  out  1  RAS holds no entries.

## Operation
- Reset: `pc_out`=`RESET_VEC`, RAS count=0, pointer=0, `ras_empty`=1. `RST` overrides every other input.
- `pc_next` is selected by this priority, highest first:
  1. `br_taken`: `br_target`. Ignores `stall`.
  2. `stall`: hold `pc_out`.
  3. `ret` & !`ras_empty`: RAS top.
  4. `jump`: `jump_target`.
  5. Otherwise: `pc_out`+`INC`, modulo 2^WL. `0xFFFFFFFC`+4 = `0x00000000`.
- `ret` with an empty RAS is treated as sequential; EX corrects it later through `br_taken`.
- All targets have bits [1:0] forced to 0 before loading.
- RAS push: `jump`&`call`&!`stall`&!`br_taken`.
  - Write `link_addr` at the pointer, then increment the pointer.
  - Count saturates at `RAS_DEPTH`. On overflow the oldest entry is overwritten (circular).
- RAS pop: `ret`&!`call`&!`stall`&!`br_taken`&count>0. Decrement the pointer and count.
- `call`&`ret` together: push only; `ret` is ignored.
- `br_taken` in the same cycle as an ID push or pop: the RAS is unchanged, because the ID instruction is squashed.
- `call` without `jump`: ignored.

## Timing
- `pc_next` is combinational from the inputs and current state. `pc_out` updates one cycle later.
- Redirect latency: a redirect asserted in cycle N appears on `pc_out` in cycle N+1.
- `stall` held for K cycles holds `pc_out` for K cycles. Sequential advance resumes on the first cycle with `stall`=0.
- RAS top is read combinationally. A push in cycle N is visible to a `ret` in cycle N+1.
- `RST` asserted mid-stream: `pc_out`=`RESET_VEC` on the next edge, regardless of `br_taken`, `stall`, or RAS activity.

## Configuration
- `PC_GEN_RAS_EN` defined: RAS is instantiated and behaves as described in Operation.
- `PC_GEN_RAS_EN` undefined:
  - No RAS storage is built.
  - `ret` and `call` are ignored; `jump` still redirects to `jump_target`.
  - `ras_empty` is tied to 1.
  - All other behaviour is identical.

## Structure
- Package `pc_gen_pkg`:
  - Enum `pc_src_t` {`SRC_SEQ`, `SRC_HOLD`, `SRC_RET`, `SRC_JUMP`, `SRC_BR`}, used for the next-PC mux select.
  - Localparam for the alignment mask.
  - Function `align(addr)`.
- Sub-module `ras_stack`:
  - Parameters `WL`, `RAS_DEPTH`.
  - Ports: `push`, `pop`, `din`, `top`, `empty`.
  - Circular buffer with pointer and saturating count.
  - Instantiated only under `PC_GEN_RAS_EN`.
- The top level holds the PC register, the priority mux, and push/pop qualification.

## Test plan
- Reset then free run: `RST` for 1 cycle with `RESET_VEC`=`0x100`. Expect `pc_out` = `0x100`, `0x104`, `0x108` on successive cycles.
- Stall vs branch: `stall`=1 for 3 cycles at `pc_out`=`0x20` → `pc_out` holds `0x20`. Then in one cycle assert `stall`=1, `br_taken`=1, `br_target`=`0x400`, plus `jump`=1, `jump_target`=`0x800`. Expect `pc_out`=`0x400` next cycle.
- Misaligned target and wrap:
  - `jump` to `0x1003` → `pc_out`=`0x1000`.
  - Start from `pc_out`=`0xFFFFFFFC` → next `pc_out`=`0x0`.
- RAS call/return:
  - `jump`+`call` to `0x200` with `link_addr`=`0x48` → `pc_out`=`0x200`, `ras_empty`=0.
  - Later `ret`=1 → `pc_out`=`0x48`, `ras_empty`=1.
- RAS overflow (`RAS_DEPTH`=4):
  - Push `0x10`, `0x20`, `0x30`, `0x40`, `0x50`.
  - Five `ret`s yield `0x50`, `0x40`, `0x30`, `0x20`, then sequential.
  - `ras_empty`=1 after the fourth pop.
- Squash and reset:
  - `ret` with `br_taken`=1, `br_target`=`0x600` → `pc_out`=`0x600` and the RAS is unchanged.
  - `RST` with `br_taken`=1 → `pc_out`=`RESET_VEC` and `ras_empty`=1.
